// File: rtl/apb_master_if.sv
// apb_master_if: command, response and APB bus signals of the APB3 requester.
interface apb_master_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  psel;
    logic                  penable;
    logic [ADDR_WIDTH-1:0] paddr;
    logic                  pwrite;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, paddr, pwrite, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, paddr, pwrite, pwdata
    );
endinterface

// File: rtl/apb_master.sv
// apb_master: APB3 requester turning a valid/ready command into single APB transfers.
// Defining APB_MASTER_TIMEOUT_EN aborts ACCESS after TIMEOUT_CYCLES wait edges.
module apb_master #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic          pclk,
    input logic          presetn,
    apb_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                state, state_d;
    logic                  psel_d, penable_d, pwrite_d, rsp_valid_d, rsp_err_d, timeout;
    logic [ADDR_WIDTH-1:0] paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_d, rsp_rdata_d;

    assign bus.cmd_ready = state == IDLE;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;

    assign timeout = state == ACCESS && !bus.pready && wait_cnt == CW'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) wait_cnt <= '0;
        else if (state == SETUP) wait_cnt <= '0;
        else if (state == ACCESS && !bus.pready) wait_cnt <= wait_cnt + 1'b1;
    end
`else
    // Never fires; the expression only keeps TIMEOUT_CYCLES referenced.
    assign timeout = TIMEOUT_CYCLES < 0;
`endif

    always_comb begin
        state_d     = state;
        psel_d      = bus.psel;
        penable_d   = bus.penable;
        paddr_d     = bus.paddr;
        pwrite_d    = bus.pwrite;
        pwdata_d    = bus.pwdata;
        rsp_valid_d = bus.rsp_valid;
        rsp_rdata_d = bus.rsp_rdata;
        rsp_err_d   = bus.rsp_err;
        case (state)
            IDLE: if (bus.cmd_valid) begin
                state_d  = SETUP;
                psel_d   = 1'b1;
                paddr_d  = bus.cmd_addr;
                pwrite_d = bus.cmd_write;
                pwdata_d = bus.cmd_wdata;
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: if (bus.pready || timeout) begin
                state_d     = RESP;
                psel_d      = 1'b0;
                penable_d   = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = (bus.pready && !bus.pwrite) ? bus.prdata : '0;
                rsp_err_d   = bus.pready ? bus.pslverr : 1'b1;
            end
            RESP: if (bus.rsp_ready) begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state         <= IDLE;
            bus.psel      <= 1'b0;
            bus.penable   <= 1'b0;
            bus.paddr     <= '0;
            bus.pwrite    <= 1'b0;
            bus.pwdata    <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            state         <= state_d;
            bus.psel      <= psel_d;
            bus.penable   <= penable_d;
            bus.paddr     <= paddr_d;
            bus.pwrite    <= pwrite_d;
            bus.pwdata    <= pwdata_d;
            bus.rsp_valid <= rsp_valid_d;
            bus.rsp_rdata <= rsp_rdata_d;
            bus.rsp_err   <= rsp_err_d;
        end
    end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed checks of apb_master against a small memory-backed APB slave.
module tb_apb_master;
    logic pclk = 1'b0;
    logic presetn;
    int   total = 0;
    int   bad = 0;
    logic [31:0] mem [256];

    apb_master_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

    apb_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .pclk(pclk),
        .presetn(presetn),
        .bus(bus)
    );

    always #5 pclk = ~pclk;

    assign bus.prdata = mem[bus.paddr];

    always @(posedge pclk)
        if (bus.psel && bus.penable && bus.pready && bus.pwrite) mem[bus.paddr] <= bus.pwdata;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [7:0] a, input logic [31:0] d);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic take();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("take_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("take_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h20] = 32'h12345678;
        presetn       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;
        repeat (3) tick();
        chk("rst_psel", 64'(bus.psel), 64'd0);
        chk("rst_penable", 64'(bus.penable), 64'd0);
        chk("rst_paddr", 64'(bus.paddr), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        presetn = 1'b1;
        tick();

        // 1: zero-wait write
        bus.pready = 1'b1;
        issue(1'b1, 8'h10, 32'hDEADBEEF);
        chk("t1_setup_psel", 64'(bus.psel), 64'd1);
        chk("t1_setup_penable", 64'(bus.penable), 64'd0);
        chk("t1_setup_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        chk("t1_paddr", 64'(bus.paddr), 64'h10);
        chk("t1_pwdata", 64'(bus.pwdata), 64'hDEADBEEF);
        chk("t1_pwrite", 64'(bus.pwrite), 64'd1);
        tick();
        chk("t1_access_penable", 64'(bus.penable), 64'd1);
        tick();
        chk("t1_resp_psel", 64'(bus.psel), 64'd0);
        chk("t1_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("t1_rsp_err", 64'(bus.rsp_err), 64'd0);
        chk("t1_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        take();

        // 2: read back
        issue(1'b0, 8'h10, 32'h0);
        chk("t2_setup_pwrite", 64'(bus.pwrite), 64'd0);
        tick();
        chk("t2_access_pwrite", 64'(bus.pwrite), 64'd0);
        tick();
        chk("t2_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("t2_rsp_rdata", 64'(bus.rsp_rdata), 64'hDEADBEEF);
        chk("t2_rsp_err", 64'(bus.rsp_err), 64'd0);
        take();

        // 3: three wait states
        bus.pready = 1'b0;
        issue(1'b0, 8'h10, 32'h0);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t3_penable", 64'(bus.penable), 64'd1);
            chk("t3_paddr", 64'(bus.paddr), 64'h10);
            chk("t3_rsp_valid_low", 64'(bus.rsp_valid), 64'd0);
            bus.pready = (i == 3);
            tick();
        end
        chk("t3_penable_done", 64'(bus.penable), 64'd0);
        chk("t3_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("t3_rsp_rdata", 64'(bus.rsp_rdata), 64'hDEADBEEF);
        take();
        tick();
        chk("t3_single_rsp", 64'(bus.rsp_valid), 64'd0);
        chk("t3_idle_psel", 64'(bus.psel), 64'd0);

        // 4: slave error on write
        bus.pslverr = 1'b1;
        issue(1'b1, 8'hFF, 32'hCAFEF00D);
        tick();
        tick();
        bus.pslverr = 1'b0;
        chk("t4_rsp_err", 64'(bus.rsp_err), 64'd1);
        chk("t4_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        chk("t4_rsp_valid", 64'(bus.rsp_valid), 64'd1);

        // 5: stalled response with a pending command
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 8'h20;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_rsp_valid", 64'(bus.rsp_valid), 64'd1);
            chk("t5_rsp_err", 64'(bus.rsp_err), 64'd1);
            chk("t5_cmd_ready", 64'(bus.cmd_ready), 64'd0);
            chk("t5_psel", 64'(bus.psel), 64'd0);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("t5_cmd_ready_back", 64'(bus.cmd_ready), 64'd1);
        chk("t5_rsp_dropped", 64'(bus.rsp_valid), 64'd0);
        tick();
        bus.cmd_valid = 1'b0;
        chk("t5_accept_psel", 64'(bus.psel), 64'd1);
        chk("t5_accept_paddr", 64'(bus.paddr), 64'h20);
        tick();
        tick();
        chk("t5_rsp_rdata", 64'(bus.rsp_rdata), 64'h12345678);
        chk("t5_rsp_err_clear", 64'(bus.rsp_err), 64'd0);
        take();

        // 6: reset during ACCESS
        bus.pready = 1'b0;
        issue(1'b0, 8'h10, 32'h0);
        tick();
        chk("t6_in_access", 64'(bus.penable), 64'd1);
        #2 presetn = 1'b0;
        #1;
        chk("t6_async_psel", 64'(bus.psel), 64'd0);
        chk("t6_async_penable", 64'(bus.penable), 64'd0);
        chk("t6_async_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        tick();
        presetn = 1'b1;
        tick();
        tick();
        chk("t6_no_rsp", 64'(bus.rsp_valid), 64'd0);
        chk("t6_idle_psel", 64'(bus.psel), 64'd0);

`ifdef APB_MASTER_TIMEOUT_EN
        issue(1'b0, 8'h10, 32'h0);
        tick();
        for (int i = 0; i < 16; i++) begin
            chk("t6_to_waiting", 64'(bus.penable), 64'd1);
            tick();
        end
        chk("t6_to_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("t6_to_rsp_err", 64'(bus.rsp_err), 64'd1);
        chk("t6_to_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        chk("t6_to_psel", 64'(bus.psel), 64'd0);
        take();
        issue(1'b0, 8'h10, 32'h0);
        tick();
        for (int i = 0; i < 16; i++) begin
            bus.pready = (i == 15);
            tick();
        end
        bus.pready = 1'b0;
        chk("t6_late_ready_err", 64'(bus.rsp_err), 64'd0);
        chk("t6_late_ready_rdata", 64'(bus.rsp_rdata), 64'hDEADBEEF);
        take();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
